// File: rtl/ni_flit_ejector_if.sv
// rtl/ni_flit_ejector_if.sv - router-to-tile ejection port bundle
interface ni_flit_ejector_if #(
  parameter int V    = 2,
  parameter int FPAY = 32
);
  localparam int FW = 2 + V + FPAY;
  localparam int VW = (V > 1) ? $clog2(V) : 1;

  logic [FW-1:0]   flit_in;
  logic            flit_in_wr;
  logic [V-1:0]    credit_out;
  logic [FPAY-1:0] out_data;
  logic [VW-1:0]   out_vc;
  logic            out_sop;
  logic            out_eop;
  logic            out_valid;
  logic            out_ready;
  logic            err_overflow;
  logic            err_vc;
  logic            err_seq;

  modport master (
    output flit_in, flit_in_wr, out_ready,
    input  credit_out, out_data, out_vc, out_sop, out_eop, out_valid,
    input  err_overflow, err_vc, err_seq
  );

  modport slave (
    input  flit_in, flit_in_wr, out_ready,
    output credit_out, out_data, out_vc, out_sop, out_eop, out_valid,
    output err_overflow, err_vc, err_seq
  );
endinterface

// File: rtl/ni_flit_ejector.sv
// rtl/ni_flit_ejector.sv - NoC local-port ejector: per-VC flit FIFOs, packet-atomic
// reassembly onto a valid/ready stream, credit return per consumed flit
module ni_flit_ejector #(
  parameter int V    = 2,
  parameter int B    = 4,
  parameter int FPAY = 32
) (
  input logic              clk,
  input logic              reset,
  ni_flit_ejector_if.slave ej
);
  localparam int FW = 2 + V + FPAY;
  localparam int VW = (V > 1) ? $clog2(V) : 1;
  localparam int AW = $clog2(B);
  localparam int CW = AW + 1;

  typedef enum logic {S_IDLE, S_LOCKED} state_t;

  logic [FW-1:0]        mem_q [V][B];
  logic [V-1:0][AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [V-1:0][CW-1:0] cnt_q, cnt_d;
  logic [FW-1:0]        head [V];
  logic [V-1:0]         full, push_vec, pop_vec;

  state_t               state_q;
  logic [VW-1:0]        lock_vc_q, rr_ptr_q;
  logic [V-1:0]         credit_q;
  logic                 err_ovf_q, err_vc_q, err_seq_q;

  logic [V-1:0]         vc_field;
  logic                 vc_onehot, wr_ok;
  logic                 disc_found, gnt_found;
  logic [VW-1:0]        disc_vc, gnt_vc, pop_vc;
  logic                 pop_en, out_valid_w;
  logic [FW-1:0]        lhead;
  int                   idx;

  assign vc_field  = ej.flit_in[FW-3:FPAY];
  assign vc_onehot = (vc_field != '0) && ((vc_field & (vc_field - V'(1))) == '0);
  assign wr_ok     = ej.flit_in_wr && vc_onehot;

  always_comb begin
    for (int k = 0; k < V; k++) begin
      head[k]     = mem_q[k][rd_ptr_q[k]];
      full[k]     = (cnt_q[k] == CW'(B));
      pop_vec[k]  = pop_en && (pop_vc == VW'(k));
      // A full FIFO still takes the write when the same edge frees a slot.
      push_vec[k] = wr_ok && vc_field[k] && (!full[k] || pop_vec[k]);
      cnt_d[k]    = cnt_q[k] + CW'(push_vec[k]) - CW'(pop_vec[k]);
    end
  end

  // Round-robin scan from rr_ptr; any stray non-header head is discarded before granting.
  always_comb begin
    disc_found = 1'b0;
    disc_vc    = '0;
    gnt_found  = 1'b0;
    gnt_vc     = '0;
    idx        = 0;
    for (int i = 0; i < V; i++) begin
      idx = (int'(rr_ptr_q) + i) % V;
      if (cnt_q[idx] != '0) begin
        if (head[idx][FW-1]) begin
          if (!gnt_found) begin
            gnt_found = 1'b1;
            gnt_vc    = VW'(idx);
          end
        end else if (!disc_found) begin
          disc_found = 1'b1;
          disc_vc    = VW'(idx);
        end
      end
    end
  end

  assign lhead       = head[lock_vc_q];
  assign out_valid_w = (state_q == S_LOCKED) && (cnt_q[lock_vc_q] != '0);

  always_comb begin
    pop_en = 1'b0;
    pop_vc = '0;
    if (state_q == S_IDLE) begin
      pop_en = disc_found;
      pop_vc = disc_vc;
    end else begin
      pop_en = out_valid_w && ej.out_ready;
      pop_vc = lock_vc_q;
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < V; k++) begin
      if (push_vec[k]) mem_q[k][wr_ptr_q[k]] <= ej.flit_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      for (int k = 0; k < V; k++) begin
        if (push_vec[k]) wr_ptr_q[k] <= wr_ptr_q[k] + AW'(1);
        if (pop_vec[k])  rd_ptr_q[k] <= rd_ptr_q[k] + AW'(1);
      end
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      lock_vc_q <= '0;
      rr_ptr_q  <= '0;
      credit_q  <= '0;
      err_ovf_q <= 1'b0;
      err_vc_q  <= 1'b0;
      err_seq_q <= 1'b0;
    end else begin
      credit_q <= pop_vec;
      if (ej.flit_in_wr && !vc_onehot)             err_vc_q  <= 1'b1;
      if (wr_ok && |(vc_field & full & ~pop_vec))  err_ovf_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (disc_found) begin
            err_seq_q <= 1'b1;
          end else if (gnt_found) begin
            state_q   <= S_LOCKED;
            lock_vc_q <= gnt_vc;
          end
        end
        S_LOCKED: begin
          if (pop_en && lhead[FW-2]) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= (lock_vc_q == VW'(V - 1)) ? '0 : lock_vc_q + VW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ej.credit_out   = credit_q;
  assign ej.out_valid    = out_valid_w;
  assign ej.out_data     = out_valid_w ? lhead[FPAY-1:0] : '0;
  assign ej.out_vc       = out_valid_w ? lock_vc_q : '0;
  assign ej.out_sop      = out_valid_w && lhead[FW-1];
  assign ej.out_eop      = out_valid_w && lhead[FW-2];
  assign ej.err_overflow = err_ovf_q;
  assign ej.err_vc       = err_vc_q;
  assign ej.err_seq      = err_seq_q;
endmodule

// File: tb/tb_ni_flit_ejector.sv
// tb/tb_ni_flit_ejector.sv - directed self-checking bench for ni_flit_ejector
module tb_ni_flit_ejector;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  logic [35:0] wq[$];
  logic [31:0] got_d [16];
  logic [2:0]  got_f [16];
  int          got_c [16];
  int          ng;

  ni_flit_ejector_if #(.V(2), .FPAY(32)) ej ();

  ni_flit_ejector #(.V(2), .B(4), .FPAY(32)) dut (
    .clk   (clk),
    .reset (reset),
    .ej    (ej)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [35:0] mk(input logic h, input logic t, input logic [1:0] vc,
                                     input logic [31:0] p);
    return {h, t, vc, p};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [35:0] f);
    ej.flit_in    = f;
    ej.flit_in_wr = 1'b1;
  endtask

  task automatic idle();
    ej.flit_in    = '0;
    ej.flit_in_wr = 1'b0;
  endtask

  // Feeds one queued flit per cycle and records every accepted output flit.
  task automatic collect(input int ncyc);
    ng = 0;
    for (int n = 0; n < ncyc; n++) begin
      if (wq.size() > 0) put(wq.pop_front());
      else idle();
      #4;
      if (ej.out_valid && ej.out_ready && ng < 16) begin
        got_d[ng] = ej.out_data;
        got_f[ng] = {ej.out_sop, ej.out_eop, ej.out_vc};
        got_c[ng] = n;
        ng++;
      end
      tick();
    end
    idle();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    ej.flit_in    = '0;
    ej.flit_in_wr = 1'b0;
    ej.out_ready  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_valid", ej.out_valid, 0);
    check_eq("rst_data", ej.out_data, 0);
    check_eq("rst_credit", ej.credit_out, 0);
    check_eq("rst_errs", {ej.err_overflow, ej.err_vc, ej.err_seq}, 0);
    reset = 1'b1;
    tick();

    // single VC0 packet, 2-cycle header latency, 3 back-to-back credits
    ej.out_ready = 1'b1;
    put(mk(1, 0, 2'b01, 32'h11)); #4; check_eq("s1_c0_valid", ej.out_valid, 0); tick();
    put(mk(0, 0, 2'b01, 32'h22)); #4; check_eq("s1_c1_valid", ej.out_valid, 0); tick();
    put(mk(0, 1, 2'b01, 32'h33)); #4;
    check_eq("s1_c2_valid", ej.out_valid, 1);
    check_eq("s1_c2_data", ej.out_data, 32'h11);
    check_eq("s1_c2_flags", {ej.out_sop, ej.out_eop, ej.out_vc}, 3'b100);
    check_eq("s1_c2_credit", ej.credit_out, 2'b00);
    tick();
    idle(); #4;
    check_eq("s1_c3_data", ej.out_data, 32'h22);
    check_eq("s1_c3_flags", {ej.out_valid, ej.out_sop, ej.out_eop}, 3'b100);
    check_eq("s1_c3_credit", ej.credit_out, 2'b01);
    tick(); #4;
    check_eq("s1_c4_data", ej.out_data, 32'h33);
    check_eq("s1_c4_flags", {ej.out_valid, ej.out_sop, ej.out_eop}, 3'b101);
    check_eq("s1_c4_credit", ej.credit_out, 2'b01);
    tick(); #4;
    check_eq("s1_c5_valid", ej.out_valid, 0);
    check_eq("s1_c5_credit", ej.credit_out, 2'b01);
    tick(); #4;
    check_eq("s1_c6_credit", ej.credit_out, 2'b00);
    tick();

    // interleaved VC0/VC1 input, output is packet-atomic with one re-arbitration gap
    wq = '{mk(1, 0, 2'b01, 32'hA0), mk(1, 0, 2'b10, 32'hB0), mk(0, 0, 2'b01, 32'hA1),
           mk(0, 0, 2'b10, 32'hB1), mk(0, 1, 2'b01, 32'hA2), mk(0, 1, 2'b10, 32'hB2)};
    collect(14);
    check_eq("s2_count", ng, 6);
    begin
      logic [31:0] ed [6];
      logic [2:0]  ef [6];
      ed = '{32'hA0, 32'hA1, 32'hA2, 32'hB0, 32'hB1, 32'hB2};
      ef = '{3'b100, 3'b000, 3'b010, 3'b101, 3'b001, 3'b011};
      for (int i = 0; i < 6; i++) begin
        check_eq($sformatf("s2_data%0d", i), got_d[i], ed[i]);
        check_eq($sformatf("s2_flags%0d", i), got_f[i], ef[i]);
      end
    end
    check_eq("s2_gap", got_c[3] - got_c[2], 2);
    check_eq("s2_b1", got_c[4] - got_c[3], 1);
    check_eq("s2_b2", got_c[5] - got_c[4], 1);

    // full VC0 FIFO written while its head is popped
    ej.out_ready = 1'b0;
    wq = '{mk(1, 0, 2'b01, 32'hD0), mk(0, 0, 2'b01, 32'hD1), mk(0, 0, 2'b01, 32'hD2),
           mk(0, 0, 2'b01, 32'hD3)};
    collect(6);
    #4;
    check_eq("s4_held_valid", ej.out_valid, 1);
    check_eq("s4_held_data", ej.out_data, 32'hD0);
    tick();
    ej.out_ready = 1'b1;
    wq = '{mk(0, 1, 2'b01, 32'hD4)};
    collect(8);
    check_eq("s4_count", ng, 5);
    for (int i = 0; i < 5; i++) check_eq($sformatf("s4_data%0d", i), got_d[i], 32'hD0 + i);
    check_eq("s4_tail", got_f[4], 3'b010);
    check_eq("s4_no_ovf", ej.err_overflow, 0);

    // backpressure on VC1, fifth write overflows
    ej.out_ready = 1'b0;
    wq = '{mk(1, 0, 2'b10, 32'hC0), mk(0, 0, 2'b10, 32'hC1), mk(0, 0, 2'b10, 32'hC2),
           mk(0, 1, 2'b10, 32'hC3), mk(0, 0, 2'b10, 32'hC4)};
    collect(7);
    check_eq("s3_ovf", ej.err_overflow, 1);
    for (int i = 0; i < 5; i++) begin
      #4;
      check_eq("s3_hold_data", ej.out_data, 32'hC0);
      check_eq("s3_hold_credit", ej.credit_out, 0);
      tick();
    end
    ej.out_ready = 1'b1;
    collect(8);
    check_eq("s3_count", ng, 4);
    check_eq("s3_last", got_d[3], 32'hC3);
    check_eq("s3_last_flags", got_f[3], 3'b011);

    // malformed VC field, then a headless body flit on VC1
    check_eq("s5_vc_pre", ej.err_vc, 0);
    put(mk(1, 1, 2'b11, 32'hEE)); #4; tick();
    idle(); #4;
    check_eq("s5_err_vc", ej.err_vc, 1);
    check_eq("s5_vc_credit", ej.credit_out, 0);
    tick();
    put(mk(0, 0, 2'b10, 32'hE0)); #4; tick();
    idle(); #4;
    check_eq("s5_m1_valid", ej.out_valid, 0);
    check_eq("s5_m1_seq", ej.err_seq, 0);
    tick(); #4;
    check_eq("s5_m2_credit", ej.credit_out, 2'b10);
    check_eq("s5_m2_seq", ej.err_seq, 1);
    check_eq("s5_m2_valid", ej.out_valid, 0);
    tick(); #4;
    check_eq("s5_m3_credit", ej.credit_out, 2'b00);
    check_eq("s5_m3_valid", ej.out_valid, 0);
    tick();

    // asynchronous reset while locked with flits buffered
    ej.out_ready = 1'b0;
    wq = '{mk(1, 0, 2'b01, 32'hF0), mk(0, 0, 2'b01, 32'hF1), mk(0, 0, 2'b01, 32'hF2)};
    collect(5);
    #4;
    check_eq("s6_pre_valid", ej.out_valid, 1);
    reset = 1'b0;
    #1;
    check_eq("s6_rst_valid", ej.out_valid, 0);
    check_eq("s6_rst_data", ej.out_data, 0);
    check_eq("s6_rst_errs", {ej.err_overflow, ej.err_vc, ej.err_seq}, 0);
    check_eq("s6_rst_credit", ej.credit_out, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    tick();
    ej.out_ready = 1'b1;
    put(mk(1, 1, 2'b01, 32'h77)); #4; tick();
    idle(); #4;
    check_eq("s6_n1_valid", ej.out_valid, 0);
    tick(); #4;
    check_eq("s6_n2_data", ej.out_data, 32'h77);
    check_eq("s6_n2_flags", {ej.out_valid, ej.out_sop, ej.out_eop}, 3'b111);
    tick(); #4;
    check_eq("s6_n3_valid", ej.out_valid, 0);
    check_eq("s6_n3_credit", ej.credit_out, 2'b01);
    tick(); #4;
    check_eq("s6_n4_credit", ej.credit_out, 2'b00);
    check_eq("s6_n4_valid", ej.out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
